// File: rtl/hog_params.sv
// Shared HOG constants: window geometry, scale-to-level table, width helper and FSM states.
package hog_params;

    localparam int unsigned DATA_WIDTH       = 32;
    localparam int unsigned HOG_WINDOW_WIDTH = 32 * 36;
    localparam int unsigned HOG_SCALE        = 9;

    function automatic int unsigned levels_for_scale(input int unsigned scale);
        case (scale)
            9:       return 15;
            6:       return 10;
            4:       return 7;
            3:       return 6;
            2:       return 5;
            default: return 4;
        endcase
    endfunction

    // Never returns 0 so that single-entry vectors still get a 1-bit index.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned HOG_LEVELS = levels_for_scale(HOG_SCALE);

    typedef enum logic {
        StIdle = 1'b0,
        StSend = 1'b1
    } state_e;

endpackage

// File: rtl/hog_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr, wrapping.
module hog_rr_arbiter
    import hog_params::*;
#(
    parameter int unsigned LEVELS = 15,
    parameter int unsigned LVL_W  = clog2_min1(LEVELS)
) (
    input  logic [LEVELS-1:0] req,
    input  logic [LVL_W-1:0]  ptr,
    output logic [LEVELS-1:0] grant,
    output logic [LVL_W-1:0]  grant_idx,
    output logic              grant_valid
);

    logic [LVL_W:0] pos;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        pos         = '0;
        for (int i = 0; i < int'(LEVELS); i++) begin
            pos = {1'b0, ptr} + (LVL_W + 1)'(i);
            if (pos >= (LVL_W + 1)'(LEVELS)) begin
                pos = pos - (LVL_W + 1)'(LEVELS);
            end
            if (!grant_valid && req[pos[LVL_W-1:0]]) begin
                grant_valid            = 1'b1;
                grant[pos[LVL_W-1:0]] = 1'b1;
                grant_idx              = pos[LVL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/hog_window_collector.sv
// Collects detection windows from all pyramid levels round-robin and streams each one
// out as WORD_WIDTH words tagged with its source level.
module hog_window_collector
    import hog_params::*;
#(
    parameter int unsigned LEVELS       = HOG_LEVELS,
    parameter int unsigned WINDOW_WIDTH = HOG_WINDOW_WIDTH,
    parameter int unsigned WORD_WIDTH   = DATA_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [WINDOW_WIDTH*LEVELS-1:0]   detection_window,
    input  logic [LEVELS-1:0]                window_valid,
    output logic [LEVELS-1:0]                window_ready,
    output logic [WORD_WIDTH-1:0]            word_out,
    output logic                             word_valid,
    input  logic                             word_ready,
    output logic [clog2_min1(LEVELS)-1:0]    word_level,
    output logic                             word_last,
    output logic [15:0]                      windows_sent
);

    localparam int unsigned WORDS = WINDOW_WIDTH / WORD_WIDTH;
    localparam int unsigned LVL_W = clog2_min1(LEVELS);
    localparam int unsigned IDX_W = clog2_min1(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    if ((WINDOW_WIDTH % WORD_WIDTH) != 0 || LEVELS < 1 || WORDS < 1) begin : g_param_check
        $error("hog_window_collector: WINDOW_WIDTH must be a multiple of WORD_WIDTH, LEVELS >= 1");
    end

    state_e                  state;
    logic [LVL_W-1:0]        ptr;
    logic [IDX_W-1:0]        word_idx;
    logic [WINDOW_WIDTH-1:0] buffer;
    logic [15:0]             windows_sent_q;
    logic [15:0]             windows_sent_d;
    logic [LEVELS-1:0]       grant;
    logic [LVL_W-1:0]        grant_idx;
    logic                    grant_valid;
    logic                    accept_last;

    hog_rr_arbiter #(
        .LEVELS (LEVELS),
        .LVL_W  (LVL_W)
    ) u_arb (
        .req         (window_valid),
        .ptr         (ptr),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign window_ready = (state == StIdle && !rst) ? grant : '0;
    // The buffer shifts down on every accepted word, so the current word is always its LSBs.
    assign word_out     = buffer[WORD_WIDTH-1:0];
    assign windows_sent = windows_sent_q;
    assign accept_last  = (state == StSend) && word_ready && word_last;

    always_comb begin
        windows_sent_d = windows_sent_q;
        if (accept_last && windows_sent_q != 16'hFFFF) begin
            windows_sent_d = windows_sent_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= StIdle;
            ptr            <= '0;
            word_idx       <= '0;
            buffer         <= '0;
            word_valid     <= 1'b0;
            word_last      <= 1'b0;
            word_level     <= '0;
            windows_sent_q <= '0;
        end else begin
            windows_sent_q <= windows_sent_d;
            case (state)
                StIdle: begin
                    if (grant_valid) begin
                        buffer     <= detection_window[grant_idx*WINDOW_WIDTH +: WINDOW_WIDTH];
                        word_level <= grant_idx;
                        word_idx   <= '0;
                        word_valid <= 1'b1;
                        word_last  <= (WORDS == 1);
                        state      <= StSend;
                    end
                end
                StSend: begin
                    if (word_ready) begin
                        buffer <= buffer >> WORD_WIDTH;
                        if (word_last) begin
                            word_valid <= 1'b0;
                            word_last  <= 1'b0;
                            ptr        <= (word_level == LVL_W'(LEVELS - 1)) ? '0
                                                                             : word_level + 1'b1;
                            state      <= StIdle;
                        end else begin
                            word_idx  <= word_idx + 1'b1;
                            word_last <= (word_idx + 1'b1 == LAST_IDX);
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_hog_window_collector.sv
// Directed bench for hog_window_collector: arbitration order, serialization, stalls,
// pointer wrap, mid-window reset and counter saturation.
module tb_hog_window_collector;

    localparam int LEVELS = 15;
    localparam int WW     = 1152;
    localparam int W      = 32;
    localparam int WORDS  = 36;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [WW*LEVELS-1:0] detection_window;
    logic [LEVELS-1:0]    window_valid;
    logic [LEVELS-1:0]    window_ready;
    logic [W-1:0]         word_out;
    logic                 word_valid;
    logic                 word_ready;
    logic [3:0]           word_level;
    logic                 word_last;
    logic [15:0]          windows_sent;

    int errors = 0;
    int checks = 0;

    hog_window_collector #(
        .LEVELS       (LEVELS),
        .WINDOW_WIDTH (WW),
        .WORD_WIDTH   (W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .detection_window (detection_window),
        .window_valid     (window_valid),
        .window_ready     (window_ready),
        .word_out         (word_out),
        .word_valid       (word_valid),
        .word_ready       (word_ready),
        .word_level       (word_level),
        .word_last        (word_last),
        .windows_sent     (windows_sent)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int lvl, input int k);
        return detection_window[lvl*WW + k*W +: W];
    endfunction

    task automatic do_reset();
        rst          = 1'b1;
        window_valid = '0;
        word_ready   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Caller has set valids; expects lvl to be granted now and streams the whole window.
    task automatic serve_window(input int lvl, input bit drop);
        #1;
        chk("grant", 32'(window_ready), 32'(1) << lvl);
        tick();
        if (drop) window_valid[lvl] = 1'b0;
        #1;
        chk("ready_in_send", 32'(window_ready), 0);
        for (int k = 0; k < WORDS; k++) begin
            chk("word_valid", 32'(word_valid), 1);
            chk("word_out", word_out, exp_word(lvl, k));
            chk("word_last", 32'(word_last), (k == WORDS - 1) ? 1 : 0);
            chk("word_level", 32'(word_level), lvl);
            tick();
        end
        chk("valid_after_last", 32'(word_valid), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cnt;
        for (int l = 0; l < LEVELS; l++) begin
            for (int k = 0; k < WORDS; k++) begin
                detection_window[l*WW + k*W +: W] = {8'(l), 8'(k), 8'(l) ^ 8'h5A, 8'(k) + 8'h11};
            end
        end

        // Reset values, with every level requesting to show ready stays low in reset.
        rst          = 1'b1;
        window_valid = '1;
        word_ready   = 1'b1;
        tick();
        tick();
        chk("rst_ready", 32'(window_ready), 0);
        chk("rst_valid", 32'(word_valid), 0);
        chk("rst_last", 32'(word_last), 0);
        chk("rst_word", word_out, 0);
        chk("rst_level", 32'(word_level), 0);
        chk("rst_sent", 32'(windows_sent), 0);

        // 1: single window from level 0.
        do_reset();
        word_ready   = 1'b1;
        window_valid = 15'h0001;
        #1;
        chk("t1_hand_word0", detection_window[31:0], 32'h0000_5A11);
        serve_window(0, 1'b1);
        chk("t1_sent", 32'(windows_sent), 1);
        tick();
        chk("t1_no_regrant", 32'(word_valid), 0);
        chk("t1_idle_word", word_out, 0);

        // 2: all levels valid, strict order 0..14 then wrap to 0, 37 cycles apart.
        do_reset();
        word_ready   = 1'b1;
        window_valid = 15'h7FFF;
        for (int w = 0; w < LEVELS; w++) serve_window(w, 1'b0);
        chk("t2_sent15", 32'(windows_sent), 15);
        serve_window(0, 1'b0);
        chk("t2_sent16", 32'(windows_sent), 16);

        // 3: level 5 with a randomly stalling consumer.
        do_reset();
        window_valid = 15'h0020;
        word_ready   = 1'b0;
        #1;
        chk("t3_grant", 32'(window_ready), 32'h20);
        cnt = 0;
        for (int c = 0; c < 400 && cnt < WORDS; c++) begin
            tick();
            if (word_valid) begin
                window_valid = '0;
                chk("t3_word", word_out, exp_word(5, cnt));
                chk("t3_last", 32'(word_last), (cnt == WORDS - 1) ? 1 : 0);
                chk("t3_level", 32'(word_level), 5);
                word_ready = 1'($urandom_range(0, 1));
                if (word_ready) cnt++;
            end else begin
                word_ready = 1'b0;
            end
        end
        tick();
        chk("t3_count", cnt, WORDS);
        chk("t3_done", 32'(word_valid), 0);
        chk("t3_sent", 32'(windows_sent), 1);

        // 4: pointer wrap 13 -> 14 -> 0.
        do_reset();
        word_ready   = 1'b1;
        window_valid = 15'h2000;
        serve_window(13, 1'b1);
        window_valid = 15'h4001;
        serve_window(14, 1'b1);
        serve_window(0, 1'b1);
        chk("t4_sent", 32'(windows_sent), 3);

        // 5: reset while word 10 of level 3 is on the output.
        do_reset();
        word_ready   = 1'b1;
        window_valid = 15'h0008;
        #1;
        chk("t5_grant", 32'(window_ready), 32'h8);
        tick();
        for (int k = 0; k < 10; k++) begin
            chk("t5_word", word_out, exp_word(3, k));
            tick();
        end
        chk("t5_word10", word_out, exp_word(3, 10));
        rst = 1'b1;
        tick();
        chk("t5_rst_valid", 32'(word_valid), 0);
        chk("t5_rst_ready", 32'(window_ready), 0);
        rst = 1'b0;
        serve_window(3, 1'b1);
        chk("t5_sent", 32'(windows_sent), 1);

        // 6: counter saturation at 16'hFFFF.
        do_reset();
        word_ready = 1'b1;
        force dut.windows_sent_q = 16'hFFFE;
        tick();
        tick();
        release dut.windows_sent_q;
        #1;
        chk("t6_preload", 32'(windows_sent), 32'hFFFE);
        window_valid = 15'h0004;
        serve_window(2, 1'b0);
        chk("t6_sent1", 32'(windows_sent), 32'hFFFF);
        serve_window(2, 1'b0);
        chk("t6_sent2", 32'(windows_sent), 32'hFFFF);
        serve_window(2, 1'b0);
        chk("t6_sent3", 32'(windows_sent), 32'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
